// File: rtl/nabp_fir_filter.sv
// Pipelined FIR filter: delay line -> per-tap products -> rounded accumulate.
// Define NABP_FIR_SATURATE_EN to clamp the output instead of wrapping it.
module nabp_fir_filter #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 18,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 8,
    parameter int FRAC_BITS  = 14,
    parameter int ADDR_WIDTH = $clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] val_in,
    input  logic                         coef_we,
    input  logic        [ADDR_WIDTH-1:0] coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic signed [OUT_WIDTH-1:0]  val_out,
    output logic                         val_out_valid
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1 << FRAC_BITS);

    logic signed [DATA_WIDTH-1:0] x_q [TAPS];
    logic signed [COEF_WIDTH-1:0] h_q [TAPS];
    logic signed [PROD_W-1:0]     p_q [TAPS];
    logic                         v1_q, v2_q, valid_q;
    logic signed [OUT_WIDTH-1:0]  out_q, out_d;
    logic signed [ACC_W-1:0]      acc, rnd;

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(p_q[k]);
        end
    end

    // Round half-up before dropping the coefficient fraction bits.
    if (FRAC_BITS > 0) begin : g_round
        localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_BITS - 1);
        assign rnd = (acc + HALF) >>> FRAC_BITS;
    end else begin : g_noround
        assign rnd = acc;
    end

`ifdef NABP_FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (OUT_WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    always_comb begin
        out_d = OUT_WIDTH'(rnd);
        if (rnd > OUT_MAX) begin
            out_d = OUT_WIDTH'(OUT_MAX);
        end else if (rnd < OUT_MIN) begin
            out_d = OUT_WIDTH'(OUT_MIN);
        end
    end
`else
    always_comb begin
        out_d = OUT_WIDTH'(rnd);
    end
`endif

    // Coefficient writes stay live during clear; only reset restores identity.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                p_q[k] <= '0;
                h_q[k] <= (k == 0) ? COEF_ONE : '0;
            end
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            if (clear) begin
                for (int k = 0; k < TAPS; k++) begin
                    x_q[k] <= '0;
                    p_q[k] <= '0;
                end
                v1_q    <= 1'b0;
                v2_q    <= 1'b0;
                valid_q <= 1'b0;
                out_q   <= '0;
            end else begin
                if (enable) begin
                    x_q[0] <= val_in;
                    for (int k = 1; k < TAPS; k++) begin
                        x_q[k] <= x_q[k-1];
                    end
                end
                v1_q <= enable;
                for (int k = 0; k < TAPS; k++) begin
                    p_q[k] <= PROD_W'(x_q[k]) * PROD_W'(h_q[k]);
                end
                v2_q    <= v1_q;
                valid_q <= v2_q;
                if (v2_q) begin
                    out_q <= out_d;
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                if (coef_we && coef_addr == ADDR_WIDTH'(k)) begin
                    h_q[k] <= coef_data;
                end
            end
        end
    end

    assign val_out       = out_q;
    assign val_out_valid = valid_q;

endmodule

// File: tb/tb_nabp_fir_filter.sv
// Directed bench for nabp_fir_filter; coefficient width widened so ramp taps up to 8.0 fit.
module tb_nabp_fir_filter;

    localparam int DW   = 16;
    localparam int OW   = 18;
    localparam int CW   = 20;
    localparam int TAPS = 8;
    localparam int FB   = 14;
    localparam int AW   = 4;

`ifdef NABP_FIR_SATURATE_EN
    localparam int SAT_POS = 131071;
    localparam int SAT_NEG = -131072;
`else
    localparam int SAT_POS = -32;
    localparam int SAT_NEG = 16;
`endif

    logic                 clk = 1'b0;
    logic                 reset, enable, clear, coef_we;
    logic signed [DW-1:0] val_in;
    logic        [AW-1:0] coef_addr;
    logic signed [CW-1:0] coef_data;
    logic signed [OW-1:0] val_out;
    logic                 val_out_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nabp_fir_filter #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .COEF_WIDTH(CW),
        .TAPS(TAPS), .FRAC_BITS(FB), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .val_in(val_in), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .val_out(val_out), .val_out_valid(val_out_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeCoef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = CW'(d);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (val_out !== '0 || val_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state got val=%0d valid=%0b expected val=0 valid=0", val_out, val_out_valid);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (val_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release got valid=%0b expected 0", val_out_valid);
        end
    endtask

    task automatic test_identity();
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            val_in = DW'((c == 0) ? 100 : 0);
            tick();
            if (c >= 2) begin
                checks++;
                if (val_out_valid !== 1'b1 || val_out !== OW'((c == 2) ? 100 : 0)) begin
                    failures++;
                    $display("[TB] FAIL identity c=%0d got val=%0d valid=%0b expected val=%0d valid=1",
                             c, val_out, val_out_valid, (c == 2) ? 100 : 0);
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_ramp();
        pulseClear();
        for (int k = 0; k < TAPS; k++) writeCoef(k, (k + 1) * 16384);
        enable = 1'b1;
        for (int c = 0; c < 13; c++) begin
            val_in = DW'((c == 0) ? 100 : 0);
            tick();
            if (c >= 2) begin
                int e;
                e = (c - 2 < TAPS) ? 100 * (c - 1) : 0;
                checks++;
                if (val_out_valid !== 1'b1 || val_out !== OW'(e)) begin
                    failures++;
                    $display("[TB] FAIL ramp c=%0d got val=%0d valid=%0b expected val=%0d valid=1",
                             c, val_out, val_out_valid, e);
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_saturate();
        int samp [2] = '{32767, -32768};
        int first [2] = '{65532, -65534};
        int last [2] = '{SAT_POS, SAT_NEG};
        for (int k = 0; k < TAPS; k++) writeCoef(k, 32767);
        for (int s = 0; s < 2; s++) begin
            pulseClear();
            for (int c = 0; c < 10; c++) begin
                enable = (c < 8);
                val_in = DW'(samp[s]);
                tick();
                if (c == 2 || c == 9) begin
                    int e;
                    e = (c == 2) ? first[s] : last[s];
                    checks++;
                    if (val_out_valid !== 1'b1 || val_out !== OW'(e)) begin
                        failures++;
                        $display("[TB] FAIL saturate s=%0d c=%0d got val=%0d valid=%0b expected val=%0d valid=1",
                                 s, c, val_out, val_out_valid, e);
                    end
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        int enS  [9] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
        int valS [9] = '{10, 99, 20, 99, 30, 99, 0, 0, 0};
        int expV [9] = '{0, 0, 1, 0, 1, 0, 1, 0, 0};
        int expO [9] = '{0, 0, 10, 10, 30, 30, 50, 50, 50};
        pulseReset();
        writeCoef(1, 16384);
        for (int c = 0; c < 9; c++) begin
            enable = enS[c][0];
            val_in = DW'(valS[c]);
            tick();
            if (c >= 2) begin
                checks++;
                if (val_out_valid !== expV[c][0] || val_out !== OW'(expO[c])) begin
                    failures++;
                    $display("[TB] FAIL toggle c=%0d got val=%0d valid=%0b expected val=%0d valid=%0d",
                             c, val_out, val_out_valid, expO[c], expV[c]);
                end
            end
        end
    endtask

    task automatic test_coef_timing();
        int enS   [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        int valS  [8] = '{50, 70, 0, 0, 40, 0, 0, 0};
        int weS   [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
        int addrS [8] = '{0, 0, 9, 0, 0, 0, 0, 0};
        int dataS [8] = '{0, 0, 12345, 16384, 0, 0, 0, 0};
        int expV  [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        int expO  [8] = '{0, 0, 50, 0, 0, 0, 40, 0};
        pulseReset();
        for (int c = 0; c < 8; c++) begin
            enable    = enS[c][0];
            val_in    = DW'(valS[c]);
            coef_we   = weS[c][0];
            coef_addr = AW'(addrS[c]);
            coef_data = CW'(dataS[c]);
            tick();
            if (c >= 2) begin
                checks++;
                if (val_out_valid !== expV[c][0] || val_out !== OW'(expO[c])) begin
                    failures++;
                    $display("[TB] FAIL coef_timing c=%0d got val=%0d valid=%0b expected val=%0d valid=%0d",
                             c, val_out, val_out_valid, expO[c], expV[c]);
                end
            end
        end
        coef_we = 1'b0;
    endtask

    task automatic test_clear();
        int enS  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int valS [8] = '{7, 8, 99, 5, 6, 0, 0, 0};
        int clrS [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        int expV [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
        int expO [8] = '{0, 0, 0, 0, 0, 5, 11, 11};
        pulseReset();
        writeCoef(1, 16384);
        for (int c = 0; c < 8; c++) begin
            enable = enS[c][0];
            val_in = DW'(valS[c]);
            clear  = clrS[c][0];
            tick();
            if (c >= 2) begin
                checks++;
                if (val_out_valid !== expV[c][0] || val_out !== OW'(expO[c])) begin
                    failures++;
                    $display("[TB] FAIL clear c=%0d got val=%0d valid=%0b expected val=%0d valid=%0d",
                             c, val_out, val_out_valid, expO[c], expV[c]);
                end
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int enS  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int valS [8] = '{7, 8, 99, 77, 33, 0, 0, 0};
        int rstS [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        int expV [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
        int expO [8] = '{0, 0, 0, 0, 0, 77, 33, 33};
        for (int c = 0; c < 8; c++) begin
            enable = enS[c][0];
            val_in = DW'(valS[c]);
            reset  = rstS[c][0];
            tick();
            if (c >= 2) begin
                checks++;
                if (val_out_valid !== expV[c][0] || val_out !== OW'(expO[c])) begin
                    failures++;
                    $display("[TB] FAIL reset_mid c=%0d got val=%0d valid=%0b expected val=%0d valid=%0d",
                             c, val_out, val_out_valid, expO[c], expV[c]);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        val_in    = '0;
        test_reset();
        test_identity();
        test_ramp();
        test_saturate();
        test_back_to_back();
        test_coef_timing();
        test_clear();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
